// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and helpers for seq_alu.
// SEQ_ALU_REM_EN adds opcode 12 (REMU) to the iterative operations.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SLL  = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4;
    localparam logic [3:0] OP_LUI  = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;
    localparam logic [3:0] OP_MULU = 4'd10;
    localparam logic [3:0] OP_DIVU = 4'd11;
    localparam logic [3:0] OP_REMU = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    function automatic int unsigned lui_shamt(int unsigned width);
        return width / 2;
    endfunction

    function automatic logic uses_iter(logic [3:0] op);
        logic r;
        r = (op == OP_MULU) || (op == OP_DIVU);
`ifdef SEQ_ALU_REM_EN
        r = r || (op == OP_REMU);
`endif
        return r;
    endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// Iterative engine: shift-add multiply (LSB first) and restoring divide (MSB first).
// SEQ_ALU_REM_EN exposes the final partial remainder as rem_nxt.
module seq_alu_iter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] prod_nxt,
`ifdef SEQ_ALU_REM_EN
    output logic [WIDTH-1:0] rem_nxt,
`endif
    output logic [WIDTH-1:0] quot_nxt
);

    logic             active_q, active_d;
    logic             div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // acc: product accumulator or partial remainder
    logic [WIDTH-1:0] acc_q, acc_d;
    // x: multiplicand (shifts left) or dividend becoming quotient
    logic [WIDTH-1:0] x_q, x_d;
    // y: multiplier (shifts right) or divisor
    logic [WIDTH-1:0] y_q, y_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;

    always_comb begin
        active_d = active_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        x_d      = x_q;
        y_d      = y_q;
        shifted  = {acc_q, x_q[WIDTH-1]};
        ge       = shifted >= {1'b0, y_q};
        diff     = shifted[WIDTH-1:0] - y_q;
        done     = active_q && (cnt_q == CNT_W'(WIDTH - 1));

        if (start) begin
            active_d = 1'b1;
            div_d    = is_div;
            cnt_d    = '0;
            acc_d    = '0;
            x_d      = a;
            y_d      = b;
        end else if (active_q) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (div_q) begin
                acc_d = ge ? diff : shifted[WIDTH-1:0];
                x_d   = {x_q[WIDTH-2:0], ge};
            end else begin
                if (y_q[0]) begin
                    acc_d = acc_q + x_q;
                end
                x_d = x_q << 1;
                y_d = y_q >> 1;
            end
            if (done) begin
                active_d = 1'b0;
            end
        end
    end

    // The top latches the final iteration's next values directly, saving a cycle.
    assign prod_nxt = acc_d;
    assign quot_nxt = x_d;
`ifdef SEQ_ALU_REM_EN
    assign rem_nxt  = acc_d;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            active_q <= 1'b0;
            div_q    <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
        end else begin
            active_q <= active_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            x_q      <= x_d;
            y_q      <= y_d;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Handshaked sequential ALU: registered single-cycle ops plus iterative MULU/DIVU.
// Define SEQ_ALU_REM_EN to build the REMU (opcode 12) remainder path.
module seq_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALUop,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Overflow,
    output logic             Zero,
    output logic             CarryOut,
    output logic             DivZero
);

    localparam int unsigned LUI_SH = lui_shamt(WIDTH);

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             divz_q, divz_d;

    logic             is_sub;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] add_res;
    logic             add_carry;
    logic             add_ovf;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf, alu_zero, alu_carry;

    logic             iter_start, iter_done;
    logic [WIDTH-1:0] prod_nxt, quot_nxt;
`ifdef SEQ_ALU_REM_EN
    logic [WIDTH-1:0] rem_nxt;
`endif

    // Single-cycle datapath; subtract-style ops share the A+~B+1 adder.
    always_comb begin
        is_sub    = (ALUop == OP_SUB) || (ALUop == OP_SLT) || (ALUop == OP_SLTU);
        b_op      = is_sub ? ~B : B;
        sum       = {1'b0, A} + {1'b0, b_op} + {{WIDTH{1'b0}}, is_sub};
        add_res   = sum[WIDTH-1:0];
        add_carry = sum[WIDTH];
        add_ovf   = (A[WIDTH-1] == b_op[WIDTH-1]) && (add_res[WIDTH-1] != A[WIDTH-1]);
        shamt     = A[SHAMT_W-1:0];

        alu_res   = '0;
        alu_ovf   = 1'b0;
        alu_zero  = 1'b0;
        alu_carry = 1'b0;
        case (ALUop)
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_ADD,
            OP_SUB: begin
                alu_res   = add_res;
                alu_ovf   = add_ovf;
                alu_zero  = (add_res == '0);
                alu_carry = add_carry;
            end
            OP_SLL:  alu_res = B << shamt;
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, ~add_carry};
            OP_LUI:  alu_res = B << LUI_SH;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, add_res[WIDTH-1] ^ add_ovf};
            OP_SRL:  alu_res = B >> shamt;
            OP_SRA:  alu_res = WIDTH'($signed(B) >>> shamt);
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        result_d   = result_q;
        ovf_d      = ovf_q;
        zero_d     = zero_q;
        carry_d    = carry_q;
        divz_d     = divz_q;
        iter_start = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d = ALUop;
                    if ((ALUop == OP_DIVU) && (B == '0)) begin
                        result_d = '1;
                        ovf_d    = 1'b0;
                        zero_d   = 1'b0;
                        carry_d  = 1'b0;
                        divz_d   = 1'b1;
                        state_d  = ST_DONE;
`ifdef SEQ_ALU_REM_EN
                    end else if ((ALUop == OP_REMU) && (B == '0)) begin
                        result_d = A;
                        ovf_d    = 1'b0;
                        zero_d   = 1'b0;
                        carry_d  = 1'b0;
                        divz_d   = 1'b0;
                        state_d  = ST_DONE;
`endif
                    end else if (uses_iter(ALUop)) begin
                        iter_start = 1'b1;
                        state_d    = ST_BUSY;
                    end else begin
                        result_d = alu_res;
                        ovf_d    = alu_ovf;
                        zero_d   = alu_zero;
                        carry_d  = alu_carry;
                        divz_d   = 1'b0;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_BUSY: begin
                if (iter_done) begin
                    case (op_q)
                        OP_DIVU: result_d = quot_nxt;
`ifdef SEQ_ALU_REM_EN
                        OP_REMU: result_d = rem_nxt;
`endif
                        default: result_d = prod_nxt;
                    endcase
                    ovf_d   = 1'b0;
                    zero_d  = 1'b0;
                    carry_d = 1'b0;
                    divz_d  = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            divz_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            divz_q   <= divz_d;
        end
    end

    seq_alu_iter #(
        .WIDTH (WIDTH),
        .CNT_W (SHAMT_W)
    ) u_iter (
        .clk      (clk),
        .resetn   (resetn),
        .start    (iter_start),
        .is_div   (ALUop != OP_MULU),
        .a        (A),
        .b        (B),
        .done     (iter_done),
        .prod_nxt (prod_nxt),
`ifdef SEQ_ALU_REM_EN
        .rem_nxt  (rem_nxt),
`endif
        .quot_nxt (quot_nxt)
    );

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign Result    = result_q;
    assign Overflow  = ovf_q;
    assign Zero      = zero_q;
    assign CarryOut  = carry_q;
    assign DivZero   = divz_q;

endmodule
